stdp_depress_ctrl: RTL and testbench
====================================

STDP_DEPRESS_CTRL -- requirements
Module: stdp_depress_ctrl

Interface
REQ-001 Parameter W_INIT, default 24'h001000: weight value loaded on reset.
REQ-002 Parameter W_MIN, default 24'h000000: lower saturation bound of the weight.
REQ-003 Parameter WINDOW, default 20: largest post-to-pre timestep delta that triggers a lookup.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 step  input  1  timestep tick; advances the post-spike timer.
REQ-007 post_spike  input  1  post-synaptic spike pulse.
REQ-008 pre_spike  input  1  pre-synaptic spike pulse; requests depression.
REQ-009 lut_idx  output  8  registered delta index driven to the depression LUT.
REQ-010 lut_data  input  24  LUT result, valid one clock edge after lut_idx changes.
REQ-011 weight_out  output  24  current synaptic weight, unsigned.
REQ-012 upd_valid  output  1  one-cycle pulse when weight_out has just been updated.
REQ-013 busy  output  1  high while a lookup/update is in flight.
REQ-014 drop_cnt  output  8  count of pre spikes dropped while busy (see Configuration).

Function
REQ-015 The timer shall be 8-bit, increment on each step cycle, saturate at 255, and clear to 0 on post_spike (clear wins over step).
REQ-016 A post_seen flag shall set on the first post_spike after reset; the timer is invalid while post_seen is 0.
REQ-017 FSM states: IDLE, WAIT, APPLY; IDLE->WAIT on accepted pre_spike; WAIT->APPLY unconditionally; APPLY->IDLE unconditionally.
REQ-018 A pre_spike in IDLE shall be accepted only if post_seen=1 and 1 <= timer <= WINDOW; otherwise it is ignored with no lookup and no upd_valid.
REQ-019 On acceptance (edge E0), lut_idx shall load the timer value sampled that cycle; lut_data is captured at edge E1.
REQ-020 At edge E2, weight_out shall become max(weight_out - lut_data, W_MIN), with the comparison done before subtraction, so no unsigned wrap.
REQ-021 upd_valid shall be high for exactly the one cycle following E2, even when lut_data=0 or the weight is already at W_MIN.
REQ-022 busy shall be high in WAIT and APPLY; lut_idx shall return to 0 when the FSM enters IDLE.
REQ-023 A pre_spike while busy=1 shall be dropped; the in-flight update is unaffected.
REQ-024 A post_spike while busy shall clear the timer only; the captured lut_idx is unaffected.
REQ-025 Simultaneous pre_spike and post_spike in IDLE: the pre check uses the pre-clear timer value, and the timer then clears.
REQ-026 A pre_spike with timer=0 (same-timestep) shall produce no lookup.

Reset
REQ-027 On rst: FSM=IDLE, timer=0, post_seen=0, lut_idx=0, weight_out=W_INIT, upd_valid=0, busy=0, drop_cnt=0.
REQ-028 rst asserted mid-operation shall abandon the in-flight update; weight_out returns to W_INIT with no upd_valid pulse.

Configuration
REQ-029 Macro STDP_DROP_CNT_EN defined: drop_cnt counts every dropped pre_spike (REQ-023), saturating at 255, and clears only on rst.
REQ-030 STDP_DROP_CNT_EN undefined: counter logic is removed and drop_cnt is tied to 0; all other behaviour is identical.

Verification
REQ-031 Defaults; post_spike, 5 step pulses, pre_spike; LUT returns 0xB4 for index 5 -> lut_idx=5, weight_out 4096->3916, upd_valid one cycle at E2.
REQ-032 post_spike, 2 steps, pre_spike; LUT 0x149 -> weight_out 4096->3767; back-to-back repeat -> 3438.
REQ-033 post_spike, 25 steps, pre_spike -> no lookup, lut_idx stays 0, no upd_valid; pre_spike after reset with no post -> same result.
REQ-034 W_INIT=100, W_MIN=10; delta 2, LUT 0x149 -> weight_out=10, upd_valid pulses; a second update -> weight stays 10, upd_valid pulses.
REQ-035 Accepted pre, then pre_spike in WAIT and in APPLY -> single update; drop_cnt=2 with STDP_DROP_CNT_EN, 0 without.
REQ-036 rst during WAIT -> next cycle weight_out=W_INIT, busy=0, no upd_valid; pre and post same cycle with timer=7 -> lookup at index 7, timer=0.

Source files
------------

// File: rtl/stdp_depress_ctrl.sv
// rtl/stdp_depress_ctrl.sv - STDP depression controller: post-spike timer, LUT lookup and saturating weight decrement (optional drop counter: STDP_DROP_CNT_EN)
module stdp_depress_ctrl #(
   parameter logic [23:0] W_INIT = 24'h001000,
   parameter logic [23:0] W_MIN  = 24'h000000,
   parameter int unsigned WINDOW = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic        post_spike,
   input  logic        pre_spike,
   output logic [7:0]  lut_idx,
   input  logic [23:0] lut_data,
   output logic [23:0] weight_out,
   output logic        upd_valid,
   output logic        busy,
   output logic [7:0]  drop_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  timer_q;
   logic        post_seen_q;
   logic [23:0] lut_q;
   logic [23:0] w_next;
   logic        in_window;
   logic        accept;

   // The timer is only meaningful once a post spike has been seen; delta 0 is a same-timestep pair.
   assign in_window = post_seen_q && (timer_q != 8'd0) && (32'(timer_q) <= WINDOW);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state, acceptance and busy decode.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pre_spike && in_window) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            busy    = 1'b1;
            state_d = APPLY;
         end
         APPLY: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Post-spike timer: post clears (priority over step), step increments and saturates at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q     <= 8'd0;
         post_seen_q <= 1'b0;
      end else if (post_spike) begin
         timer_q     <= 8'd0;
         post_seen_q <= 1'b1;
      end else if (step && (timer_q != 8'hFF)) begin
         timer_q     <= timer_q + 8'd1;
      end
   end

   // Saturating subtraction: compare first so the unsigned difference never wraps below W_MIN.
   always_comb begin
      w_next = W_MIN;
      if (weight_out > lut_q) begin
         if ((weight_out - lut_q) > W_MIN) w_next = weight_out - lut_q;
      end
   end

   // Lookup index, LUT capture and weight update across the WAIT/APPLY sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         lut_idx    <= 8'd0;
         lut_q      <= 24'd0;
         weight_out <= W_INIT;
         upd_valid  <= 1'b0;
      end else begin
         upd_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) lut_idx <= timer_q;
            end
            WAIT: begin
               lut_q <= lut_data;
            end
            APPLY: begin
               weight_out <= w_next;
               upd_valid  <= 1'b1;
               lut_idx    <= 8'd0;
            end
            default: lut_idx <= 8'd0;
         endcase
      end
   end

`ifdef STDP_DROP_CNT_EN
   // Count pre spikes that arrive while an update is in flight, saturating at 255.
   always_ff @(posedge clk) begin
      if (rst)                                       drop_cnt <= 8'd0;
      else if (busy && pre_spike && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`else
   assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_stdp_depress_ctrl.sv
// tb/tb_stdp_depress_ctrl.sv - scoreboard bench for stdp_depress_ctrl (default and W_INIT=100/W_MIN=10 instances)
module tb_stdp_depress_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        step = 1'b0;
   logic        post_spike = 1'b0;
   logic        pre_spike = 1'b0;
   logic [7:0]  lut_idx0, lut_idx1;
   logic [23:0] lut_data0, lut_data1;
   logic [23:0] weight_out0, weight_out1;
   logic        upd_valid0, upd_valid1;
   logic        busy0, busy1;
   logic [7:0]  drop_cnt0, drop_cnt1;

   logic [23:0] lut_mem [256];

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   localparam int WIN = 20;
   localparam int W0_INIT = 4096, W0_MIN = 0;
   localparam int W1_INIT = 100,  W1_MIN = 10;

   typedef struct {int w0; int w1;} exp_t;
   exp_t sb[$];

   int m_timer, m_seen, m_busy_rem, m_idx, m_drops, m_w0, m_w1;
   bit m_upd;

   always #5 clk = ~clk;

   assign lut_data0 = lut_mem[lut_idx0];
   assign lut_data1 = lut_mem[lut_idx1];

   stdp_depress_ctrl u_dut0 (
      .clk(clk), .rst(rst), .step(step), .post_spike(post_spike), .pre_spike(pre_spike),
      .lut_idx(lut_idx0), .lut_data(lut_data0), .weight_out(weight_out0),
      .upd_valid(upd_valid0), .busy(busy0), .drop_cnt(drop_cnt0));

   stdp_depress_ctrl #(.W_INIT(24'd100), .W_MIN(24'd10), .WINDOW(20)) u_dut1 (
      .clk(clk), .rst(rst), .step(step), .post_spike(post_spike), .pre_spike(pre_spike),
      .lut_idx(lut_idx1), .lut_data(lut_data1), .weight_out(weight_out1),
      .upd_valid(upd_valid1), .busy(busy1), .drop_cnt(drop_cnt1));

   task automatic chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sat_sub(int w, int d, int wmin);
      int r;
      r = w - d;
      return (r < wmin) ? wmin : r;
   endfunction

   function automatic int exp_drop();
`ifdef STDP_DROP_CNT_EN
      return m_drops;
`else
      return 0;
`endif
   endfunction

   // Behavioural model of one clock edge, evaluated with the inputs about to be sampled.
   task automatic model_edge(bit s, bit po, bit pr, bit r);
      m_upd = 1'b0;
      if (r) begin
         m_timer = 0; m_seen = 0; m_busy_rem = 0; m_idx = 0; m_drops = 0;
         m_w0 = W0_INIT; m_w1 = W1_INIT;
         sb.delete();
         return;
      end
      if (m_busy_rem > 0) begin
         if (pr && m_drops < 255) m_drops++;
         m_busy_rem--;
         if (m_busy_rem == 0) m_upd = 1'b1;
      end else if (pr && m_seen != 0 && m_timer >= 1 && m_timer <= WIN) begin
         m_idx = m_timer;
         m_w0 = sat_sub(m_w0, int'(lut_mem[m_timer]), W0_MIN);
         m_w1 = sat_sub(m_w1, int'(lut_mem[m_timer]), W1_MIN);
         sb.push_back('{m_w0, m_w1});
         m_busy_rem = 2;
      end
      if (po) begin
         m_timer = 0;
         m_seen  = 1;
      end else if (s && m_timer < 255) begin
         m_timer++;
      end
   endtask

   task automatic cyc(bit s, bit po, bit pr, bit r);
      @(negedge clk);
      #1;
      step = s; post_spike = po; pre_spike = pr; rst = r;
      model_edge(s, po, pr, r);
      @(posedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
   endtask

   // Monitor: compares outputs against the model away from the active edge; pops on each update pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy0", int'(busy0), int'(m_busy_rem > 0));
         chk("busy1", int'(busy1), int'(m_busy_rem > 0));
         chk("lut_idx0", int'(lut_idx0), (m_busy_rem > 0) ? m_idx : 0);
         chk("lut_idx1", int'(lut_idx1), (m_busy_rem > 0) ? m_idx : 0);
         chk("upd_valid0", int'(upd_valid0), int'(m_upd));
         chk("upd_valid1", int'(upd_valid1), int'(m_upd));
         chk("drop_cnt0", int'(drop_cnt0), exp_drop());
         chk("drop_cnt1", int'(drop_cnt1), exp_drop());
         if (upd_valid0 === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_upd", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("weight0", int'(weight_out0), e.w0);
               chk("weight1", int'(weight_out1), e.w1);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++)
         lut_mem[i] = ($urandom_range(0, 9) == 0) ? 24'd0 : 24'($urandom_range(1, 600));
      lut_mem[5] = 24'h0000B4;
      lut_mem[2] = 24'h000149;

      // Reset state
      cyc(0, 0, 0, 1);
      mon_en = 1'b1;
      #2;
      chk("rst_weight0", int'(weight_out0), 4096);
      chk("rst_weight1", int'(weight_out1), 100);
      chk("rst_lut_idx", int'(lut_idx0), 0);
      chk("rst_busy", int'(busy0), 0);

      // Delta 5, LUT 0xB4: 4096 -> 3916, and 100 -> 10
      cyc(0, 1, 0, 0);
      steps(5);
      cyc(0, 0, 1, 0);
      #2 chk("idx5", int'(lut_idx0), 5);
      idle(3);
      #2;
      chk("w031_0", int'(weight_out0), 3916);
      chk("w031_1", int'(weight_out1), 10);

      // Delta 2, LUT 0x149, back-to-back: 4096 -> 3767 -> 3438; instance 1 pinned at W_MIN
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0);
      steps(2);
      cyc(0, 0, 1, 0);
      idle(2);
      #2 chk("w032a", int'(weight_out0), 3767);
      cyc(0, 0, 1, 0);
      idle(3);
      #2;
      chk("w032b", int'(weight_out0), 3438);
      chk("w034_floor", int'(weight_out1), 10);

      // Out-of-window delta and pre without any post: ignored
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      idle(2);
      cyc(0, 1, 0, 0);
      steps(25);
      cyc(0, 0, 1, 0);
      steps(1);
      cyc(0, 0, 1, 0);
      idle(3);
      #2 chk("w033", int'(weight_out0), 4096);

      // Boundary deltas: WINDOW accepted, WINDOW+1 ignored, 0 ignored
      cyc(0, 1, 0, 0);
      steps(20);
      cyc(0, 0, 1, 0);
      #2 chk("idx_window", int'(lut_idx0), 20);
      idle(3);
      cyc(0, 1, 0, 0);
      steps(21);
      cyc(0, 0, 1, 0);
      idle(2);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      idle(2);

      // Pre spikes in WAIT and APPLY are dropped; single update
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0);
      steps(3);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      idle(2);
`ifdef STDP_DROP_CNT_EN
      #2 chk("drop035", int'(drop_cnt0), 2);
`else
      #2 chk("drop035", int'(drop_cnt0), 0);
`endif

      // Reset during WAIT abandons the update
      cyc(0, 1, 0, 0);
      steps(3);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      #2;
      chk("w036_rst", int'(weight_out0), 4096);
      chk("busy036_rst", int'(busy0), 0);
      idle(3);

      // Simultaneous pre and post with timer 7: lookup at 7, timer cleared
      cyc(0, 1, 0, 0);
      steps(7);
      cyc(0, 1, 1, 0);
      #2 chk("idx036", int'(lut_idx0), 7);
      idle(3);
      cyc(0, 0, 1, 0);
      idle(3);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++)
         cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) == 0));
      idle(4);
      @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
